// File: rtl/adder_issue_controller.sv
// Issue controller for a vector add/subtract: streams operand pairs from two RAMs into
// an external adder and writes each completed result back to a result RAM.
module adder_issue_controller (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic [7:0]  vec_len,
   input  logic        op_sel,
   output logic        mem_rd_en,
   output logic [6:0]  opa_addr,
   output logic [6:0]  opb_addr,
   input  logic [31:0] opa_data,
   input  logic [31:0] opb_data,
   output logic [31:0] adder_a,
   output logic [31:0] adder_b,
   output logic        adder_op,
   output logic        adder_start,
   input  logic        adder_finish_dash,
   input  logic [31:0] adder_result,
   output logic        iteration_reinitialization,
   output logic        res_wr_en,
   output logic [6:0]  res_addr,
   output logic [31:0] res_data,
   output logic        busy,
   output logic        done,
   output logic        protocol_err
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [7:0] len;
   logic       op_q;
   logic [7:0] issue_cnt;
   logic [7:0] issue_nx;
   logic [7:0] wr_cnt;
   logic [7:0] outstanding;
   logic       rd_valid;
   logic       fin_ok;
   logic [7:0] len_clamped;

   assign len_clamped = (vec_len > 8'd128) ? 8'd128 : vec_len;
   assign fin_ok      = adder_finish_dash && (outstanding != 8'd0);

   always_comb begin
      state_nx = state;
      issue_nx = issue_cnt;
      case (state)
         IDLE: begin
            if (go) state_nx = CLEAR;
         end
         CLEAR: begin
            issue_nx = '0;
            state_nx = (len == 8'd0) ? DONE : ISSUE;
         end
         ISSUE: begin
            issue_nx = issue_cnt + 8'd1;
            if (issue_cnt == len - 8'd1) state_nx = DRAIN;
         end
         DRAIN: begin
            // wr_cnt already advanced past the final element when its write is visible
            if (res_wr_en && (wr_cnt == len)) state_nx = DONE;
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                      <= IDLE;
         len                        <= '0;
         op_q                       <= 1'b0;
         issue_cnt                  <= '0;
         wr_cnt                     <= '0;
         outstanding                <= '0;
         rd_valid                   <= 1'b0;
         mem_rd_en                  <= 1'b0;
         opa_addr                   <= '0;
         opb_addr                   <= '0;
         adder_a                    <= '0;
         adder_b                    <= '0;
         adder_op                   <= 1'b0;
         adder_start                <= 1'b0;
         iteration_reinitialization <= 1'b0;
         res_wr_en                  <= 1'b0;
         res_addr                   <= '0;
         res_data                   <= '0;
         busy                       <= 1'b0;
         done                       <= 1'b0;
         protocol_err               <= 1'b0;
      end else begin
         state     <= state_nx;
         issue_cnt <= issue_nx;

         if ((state == IDLE) && go) begin
            len  <= len_clamped;
            op_q <= op_sel;
         end

         // Outputs are registered from next-state values so they align with the state register
         mem_rd_en <= (state_nx == ISSUE);
         if (state_nx == ISSUE) begin
            opa_addr <= issue_nx[6:0];
            opb_addr <= issue_nx[6:0];
         end

         rd_valid    <= mem_rd_en;
         adder_start <= rd_valid;
         if (rd_valid) begin
            adder_a  <= opa_data;
            adder_b  <= opb_data;
            adder_op <= op_q;
         end

         outstanding <= outstanding + {7'd0, rd_valid} - {7'd0, fin_ok};

         res_wr_en <= fin_ok;
         if (fin_ok) begin
            res_data <= adder_result;
            res_addr <= wr_cnt[6:0];
         end

         if (state == CLEAR) wr_cnt <= '0;
         else if (fin_ok)    wr_cnt <= wr_cnt + 8'd1;

         if (adder_finish_dash && (outstanding == 8'd0)) protocol_err <= 1'b1;

         iteration_reinitialization <= (state_nx != CLEAR);
         busy                       <= (state_nx != IDLE);
         done                       <= (state_nx == DONE);
      end
   end

endmodule

// File: tb/tb_adder_issue_controller.sv
// Directed bench for adder_issue_controller: operand RAM and two-cycle adder models,
// a cycle monitor, and hand-computed expectations for each scenario.
module tb_adder_issue_controller;

   logic        clk;
   logic        rst_n;
   logic        go;
   logic [7:0]  vec_len;
   logic        op_sel;
   logic        mem_rd_en;
   logic [6:0]  opa_addr;
   logic [6:0]  opb_addr;
   logic [31:0] opa_data;
   logic [31:0] opb_data;
   logic [31:0] adder_a;
   logic [31:0] adder_b;
   logic        adder_op;
   logic        adder_start;
   logic        adder_finish_dash;
   logic [31:0] adder_result;
   logic        iteration_reinitialization;
   logic        res_wr_en;
   logic [6:0]  res_addr;
   logic [31:0] res_data;
   logic        busy;
   logic        done;
   logic        protocol_err;

   adder_issue_controller dut (
      .clk                        (clk),
      .rst_n                      (rst_n),
      .go                         (go),
      .vec_len                    (vec_len),
      .op_sel                     (op_sel),
      .mem_rd_en                  (mem_rd_en),
      .opa_addr                   (opa_addr),
      .opb_addr                   (opb_addr),
      .opa_data                   (opa_data),
      .opb_data                   (opb_data),
      .adder_a                    (adder_a),
      .adder_b                    (adder_b),
      .adder_op                   (adder_op),
      .adder_start                (adder_start),
      .adder_finish_dash          (adder_finish_dash),
      .adder_result               (adder_result),
      .iteration_reinitialization (iteration_reinitialization),
      .res_wr_en                  (res_wr_en),
      .res_addr                   (res_addr),
      .res_data                   (res_data),
      .busy                       (busy),
      .done                       (done),
      .protocol_err               (protocol_err)
   );

   int          checks;
   int          errors;
   int          cyc;
   logic [31:0] mem_a [128];
   logic [31:0] mem_b [128];
   logic [31:0] exp_data [128];
   logic        exp_op;
   logic        force_fin;
   logic        s1_v;
   logic [31:0] s1_res;
   logic        fin_q;
   logic [31:0] res_q;

   int n_rd, n_st, n_wr, n_wr_tot, n_done, n_clr;
   int first_rd, first_wr, last_wr, done_cyc, clr_last, clr_prev;
   int go_cyc, d_base;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_rd_en) begin
         opa_data <= mem_a[opa_addr];
         opb_data <= mem_b[opb_addr];
      end
   end

   // Positive normal single-precision add, truncating
   function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
      logic [7:0]  ex;
      logic [7:0]  ey;
      logic [24:0] mx;
      logic [24:0] my;
      logic [24:0] ms;
      ex = x[30:23];
      ey = y[30:23];
      mx = {2'b01, x[22:0]};
      my = {2'b01, y[22:0]};
      if (ex < ey) begin
         mx = mx >> (ey - ex);
         ex = ey;
      end else begin
         my = my >> (ex - ey);
      end
      ms = mx + my;
      if (ms[24]) begin
         ms = ms >> 1;
         ex = ex + 8'd1;
      end
      return {1'b0, ex, ms[22:0]};
   endfunction

   // Adder: finish two cycles after start; op=1 is an integer difference
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v   <= 1'b0;
         s1_res <= '0;
         fin_q  <= 1'b0;
         res_q  <= '0;
      end else begin
         s1_v   <= adder_start;
         s1_res <= adder_op ? (adder_a - adder_b) : fadd(adder_a, adder_b);
         fin_q  <= s1_v;
         res_q  <= s1_res;
      end
   end

   assign adder_finish_dash = fin_q | force_fin;
   assign adder_result      = res_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (!iteration_reinitialization && busy) begin
               n_clr++;
               clr_prev = clr_last;
               clr_last = cyc;
               n_rd = 0;
               n_st = 0;
               n_wr = 0;
            end
            if (mem_rd_en) begin
               if (n_rd == 0) first_rd = cyc;
               check("opa_addr", {25'd0, opa_addr}, n_rd);
               check("opb_addr", {25'd0, opb_addr}, n_rd);
               n_rd++;
            end
            if (adder_start) begin
               check("adder_op", {31'd0, adder_op}, {31'd0, exp_op});
               n_st++;
            end
            if (res_wr_en) begin
               if (n_wr == 0) first_wr = cyc;
               check("res_addr", {25'd0, res_addr}, n_wr);
               check("res_data", res_data, exp_data[n_wr % 128]);
               n_wr++;
               n_wr_tot++;
               last_wr = cyc;
            end
            if (done) begin
               n_done++;
               done_cyc = cyc;
            end
         end
      end
   endtask

   task automatic start(input logic [7:0] len, input logic op);
      d_base  = n_done;
      go      = 1'b1;
      vec_len = len;
      op_sel  = op;
      go_cyc  = cyc;
      tick();
      go      = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && n_done == d_base; i++) tick();
      check("done_seen", n_done - d_base, 1);
   endtask

   int c0;
   int dn0;
   int w0;

   initial begin
      checks = 0; errors = 0; cyc = 0;
      n_rd = 0; n_st = 0; n_wr = 0; n_wr_tot = 0; n_done = 0; n_clr = 0;
      first_rd = 0; first_wr = 0; last_wr = 0; done_cyc = 0; clr_last = 0; clr_prev = 0;
      rst_n = 1'b1; go = 1'b0; vec_len = '0; op_sel = 1'b0; force_fin = 1'b0; exp_op = 1'b0;
      for (int i = 0; i < 128; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
         exp_data[i] = '0;
      end
      fork
         monitor();
      join_none

      #3 rst_n = 1'b0;
      #2;
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_iri", {31'd0, iteration_reinitialization}, 0);
      check("rst_flags", {27'd0, mem_rd_en, adder_start, res_wr_en, done, protocol_err}, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_iri", {31'd0, iteration_reinitialization}, 1);
      check("post_rst_busy", {31'd0, busy}, 0);

      // 4 float adds: 1..4 + 2.0
      mem_a[0] = 32'h3F80_0000; mem_a[1] = 32'h4000_0000;
      mem_a[2] = 32'h4040_0000; mem_a[3] = 32'h4080_0000;
      for (int i = 0; i < 4; i++) mem_b[i] = 32'h4000_0000;
      exp_data[0] = 32'h4040_0000; exp_data[1] = 32'h4080_0000;
      exp_data[2] = 32'h40A0_0000; exp_data[3] = 32'h40C0_0000;
      exp_op = 1'b0;
      c0 = n_clr;
      start(8'd4, 1'b0);
      wait_done(60);
      check("f4_reads", n_rd, 4);
      check("f4_starts", n_st, 4);
      check("f4_writes", n_wr, 4);
      check("f4_rd_lat", first_rd - go_cyc, 2);
      check("f4_wr_lat", first_wr - first_rd, 5);
      check("f4_done_lat", done_cyc - last_wr, 1);
      check("f4_done_abs", done_cyc - go_cyc, 11);
      check("f4_clr_cnt", n_clr - c0, 1);
      check("f4_perr", {31'd0, protocol_err}, 0);
      tick();
      check("f4_idle_busy", {31'd0, busy}, 0);

      // zero length
      c0 = n_clr;
      start(8'd0, 1'b0);
      wait_done(20);
      check("z_done_lat", done_cyc - go_cyc, 2);
      check("z_reads", n_rd, 0);
      check("z_starts", n_st, 0);
      check("z_writes", n_wr, 0);
      check("z_clr_cnt", n_clr - c0, 1);

      // length clamp with subtract
      for (int i = 0; i < 128; i++) begin
         mem_a[i]    = 32'(100 + 3 * i);
         mem_b[i]    = 32'(i);
         exp_data[i] = 32'(100 + 2 * i);
      end
      exp_op = 1'b1;
      tick();
      start(8'd200, 1'b1);
      wait_done(400);
      check("c_reads", n_rd, 128);
      check("c_starts", n_st, 128);
      check("c_writes", n_wr, 128);
      check("c_done_abs", done_cyc - go_cyc, 135);
      check("c_wr_lat", first_wr - first_rd, 5);

      // spurious finish while idle
      tick();
      w0 = n_wr_tot;
      force_fin = 1'b1;
      tick();
      force_fin = 1'b0;
      check("perr_set", {31'd0, protocol_err}, 1);
      repeat (5) tick();
      check("perr_sticky", {31'd0, protocol_err}, 1);
      check("perr_nowrite", n_wr_tot - w0, 0);
      check("perr_busy", {31'd0, busy}, 0);

      // reset during drain
      start(8'd16, 1'b1);
      for (int i = 0; i < 40 && !(n_rd == 16 && !mem_rd_en); i++) tick();
      check("drain_reached", n_rd, 16);
      w0  = n_wr_tot;
      dn0 = n_done;
      rst_n = 1'b0;
      #1;
      check("mid_rst_flags", {26'd0, busy, mem_rd_en, adder_start, res_wr_en, done, protocol_err}, 0);
      check("mid_rst_iri", {31'd0, iteration_reinitialization}, 0);
      check("mid_rst_res_data", res_data, 0);
      check("mid_rst_adder_a", adder_a, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      check("rel_no_done", n_done - dn0, 0);
      check("rel_no_write", n_wr_tot - w0, 0);
      check("rel_busy", {31'd0, busy}, 0);
      check("rel_iri", {31'd0, iteration_reinitialization}, 1);
      check("rel_perr", {31'd0, protocol_err}, 0);
      start(8'd2, 1'b1);
      wait_done(40);
      check("r2_reads", n_rd, 2);
      check("r2_writes", n_wr, 2);
      check("r2_perr", {31'd0, protocol_err}, 0);

      // go held high across two runs
      tick();
      c0  = n_clr;
      dn0 = n_done;
      go = 1'b1; vec_len = 8'd3; op_sel = 1'b1; go_cyc = cyc;
      for (int i = 0; i < 60 && (n_done - dn0) < 2; i++) tick();
      go = 1'b0;
      check("hold_dones", n_done - dn0, 2);
      check("hold_clr_cnt", n_clr - c0, 2);
      check("hold_clr1", clr_prev - go_cyc, 1);
      check("hold_clr2", clr_last - go_cyc, 12);
      check("hold_writes", n_wr, 3);
      repeat (5) tick();
      check("hold_no_third", n_clr - c0, 2);
      check("hold_idle", {31'd0, busy}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
